// File: rtl/oh_pwr_seq_pkg.sv
// Shared types for the oh_pwr_seq power sequencer: state encoding and
// the counter-width helper used to size the step/settle/timeout counter.
package oh_pwr_seq_pkg;

    typedef enum logic [2:0] {
        PWR_OFF,
        PWR_RAMPUP,
        PWR_SETTLE,
        PWR_UNRST,
        PWR_ON,
        PWR_ISO,
        PWR_RAMPDN
    } oh_pwr_state_t;

    function automatic int cnt_width(input int step, input int settle, input int timeout);
        int m;
        m = step;
        if (settle > m) m = settle;
        if (timeout > m) m = timeout;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/oh_dsync.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module oh_dsync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/oh_pwr_seq.sv
// Power-up/down sequencer for one switchable domain: staggered header-switch
// ramp, settle, isolation and reset release. OH_PWR_SEQ_PGOOD_EN adds pgood gating with timeout.
module oh_pwr_seq
    import oh_pwr_seq_pkg::*;
#(
    parameter int N       = 4,
    parameter int STEP    = 3,
    parameter int SETTLE  = 5,
    parameter int TIMEOUT = 20
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         req,
    input  logic         pgood,
    output logic [N-1:0] sw_en,
    output logic         iso,
    output logic         drst_n,
    output logic         ack,
    output logic         busy,
    output logic         err
);

    localparam int CW = cnt_width(STEP, SETTLE, TIMEOUT);
    localparam logic [CW-1:0] STEP_LAST   = CW'(STEP - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    oh_pwr_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sw_q, sw_d;
    logic          iso_q, iso_d;
    logic          drst_q, drst_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          busy_q;

`ifdef OH_PWR_SEQ_PGOOD_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    logic pgood_s;

    oh_dsync #(.STAGES(2)) u_pgood_sync (
        .clk    (clk),
        .nreset (nreset),
        .din    (pgood),
        .dout   (pgood_s)
    );
`else
    logic pgood_unused;
    assign pgood_unused = pgood;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        iso_d   = iso_q;
        drst_d  = drst_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            PWR_OFF: begin
                if (req) begin
                    state_d = PWR_RAMPUP;
                    sw_d    = {{(N-1){1'b0}}, 1'b1};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            PWR_RAMPUP: begin
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    if (&sw_q) begin
                        state_d = PWR_SETTLE;
                    end else begin
                        sw_d = {sw_q[N-2:0], 1'b1};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PWR_SETTLE: begin
`ifdef OH_PWR_SEQ_PGOOD_EN
                if (cnt_q >= SETTLE_LAST && pgood_s) begin
                    iso_d   = 1'b0;
                    state_d = PWR_UNRST;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Rail never came good: abandon and ramp back down.
                    err_d   = 1'b1;
                    iso_d   = 1'b1;
                    drst_d  = 1'b0;
                    ack_d   = 1'b0;
                    state_d = PWR_RAMPDN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`else
                if (cnt_q == SETTLE_LAST) begin
                    iso_d   = 1'b0;
                    state_d = PWR_UNRST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            PWR_UNRST: begin
                drst_d  = 1'b1;
                ack_d   = 1'b1;
                state_d = PWR_ON;
                cnt_d   = '0;
            end
            PWR_ON: begin
                if (!req) begin
                    drst_d  = 1'b0;
                    ack_d   = 1'b0;
                    state_d = PWR_ISO;
                    cnt_d   = '0;
                end
            end
            PWR_ISO: begin
                iso_d   = 1'b1;
                state_d = PWR_RAMPDN;
                cnt_d   = '0;
            end
            PWR_RAMPDN: begin
                // Shift right so the highest segment drops first.
                if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    sw_d  = {1'b0, sw_q[N-1:1]};
                    if (sw_q[N-1:1] == '0) begin
                        state_d = PWR_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = PWR_OFF;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= PWR_OFF;
            cnt_q   <= '0;
            sw_q    <= '0;
            iso_q   <= 1'b1;
            drst_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            iso_q   <= iso_d;
            drst_q  <= drst_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= !(state_d == PWR_OFF || state_d == PWR_ON);
        end
    end

    assign sw_en  = sw_q;
    assign iso    = iso_q;
    assign drst_n = drst_q;
    assign ack    = ack_q;
    assign busy   = busy_q;
    assign err    = err_q;

endmodule

// File: tb/tb_oh_pwr_seq.sv
// Scoreboard bench for oh_pwr_seq: expected output transitions are queued
// with their cycle numbers and a negedge monitor matches every output change.
module tb_oh_pwr_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         req = 1'b0;
    logic         pgood = 1'b1;
    logic [N-1:0] sw_en;
    logic         iso;
    logic         drst_n;
    logic         ack;
    logic         busy;
    logic         err;

    oh_pwr_seq #(
        .N(4), .STEP(3), .SETTLE(5), .TIMEOUT(20)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .req    (req),
        .pgood  (pgood),
        .sw_en  (sw_en),
        .iso    (iso),
        .drst_n (drst_n),
        .ack    (ack),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         cycle;
        logic [8:0] vec;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic monitorOn = 1'b0;
    logic [8:0] prevVec = 9'b0;

    function automatic logic [8:0] mk(input logic [3:0] sw, input logic i, input logic d,
                                      input logic a, input logic b, input logic e);
        return {sw, i, d, a, b, e};
    endfunction

    task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] want,
                               input int actCyc, input int wantCyc);
        checks++;
        if (act !== want || actCyc != wantCyc) begin
            errors++;
            $display("[TB] FAIL %s: got {sw,iso,drst_n,ack,busy,err}=%b at cycle %0d, need %b at cycle %0d",
                     name, act, actCyc, want, wantCyc);
        end
    endtask

    task automatic pushExp(input string name, input int c, input logic [8:0] v);
        exp_t e;
        e.name  = name;
        e.cycle = c;
        e.vec   = v;
        expQ.push_back(e);
    endtask

    // Ramp steps always; settle/unreset events only when full is set.
    task automatic pushUp(input int e0, input logic full);
        logic [3:0] s;
        s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            s = {s[2:0], 1'b1};
            pushExp($sformatf("up_sw%0d", k), e0 + 3 * k, mk(s, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        if (full) begin
            pushExp("up_iso", e0 + 17, mk(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
            pushExp("up_ack", e0 + 18, mk(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        end
    endtask

    task automatic pushDown(input int d0);
        logic [3:0] s;
        pushExp("dn_ack", d0, mk(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        pushExp("dn_iso", d0 + 1, mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        s = 4'b1111;
        for (int k = 1; k <= 4; k++) begin
            s = s >> 1;
            pushExp($sformatf("dn_sw%0d", k), d0 + 3 * k + 1,
                    mk(s, 1'b1, 1'b0, 1'b0, (s != 4'b0000), 1'b0));
        end
    endtask

    task automatic applyStimulus(input logic r, output int edgeCyc);
        @(negedge clk);
        req = r;
        edgeCyc = cyc + 1;
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [8:0] cur;
        exp_t e;
        cur = {sw_en, iso, drst_n, ack, busy, err};
        if (monitorOn && cur !== prevVec) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_change: got %b at cycle %0d, need no change from %b",
                         cur, cyc, prevVec);
            end else begin
                e = expQ.pop_front();
                checkOutput(e.name, cur, e.vec, cyc, e.cycle);
            end
        end
        prevVec <= cur;
    end

    initial begin
        int e0;
        int e1;
        int d0;
        int guard;

        #7;
        checkOutput("reset", {sw_en, iso, drst_n, ack, busy, err},
                    mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 0, 0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        monitorOn = 1'b1;

        $display("[TB] power-up then power-down");
        applyStimulus(1'b1, e0);
        pushUp(e0, 1'b1);
        waitUntil(e0 + 20);
        applyStimulus(1'b0, d0);
        pushDown(d0);
        waitUntil(d0 + 15);

        $display("[TB] req dropped mid-ramp");
        applyStimulus(1'b1, e0);
        pushUp(e0, 1'b1);
        pushDown(e0 + 19);
        waitUntil(e0 + 4);
        req = 1'b0;
        waitUntil(e0 + 19 + 15);

        $display("[TB] reset mid-ramp");
        applyStimulus(1'b1, e0);
        pushUp(e0, 1'b0);
        waitUntil(e0 + 9);
        @(posedge clk);
        #2;
        pushExp("midreset", e0 + 10, mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        nreset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        e1 = cyc + 1;
        pushUp(e1, 1'b1);
        waitUntil(e1 + 20);
        applyStimulus(1'b0, d0);
        pushDown(d0);
        waitUntil(d0 + 15);

`ifdef OH_PWR_SEQ_PGOOD_EN
        $display("[TB] pgood timeout");
        pgood = 1'b0;
        applyStimulus(1'b1, e0);
        pushUp(e0, 1'b0);
        waitUntil(e0 + 2);
        req = 1'b0;
        pushExp("to_err",  e0 + 32, mk(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        pushExp("to_sw3",  e0 + 35, mk(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        pushExp("to_sw2",  e0 + 38, mk(4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        pushExp("to_sw1",  e0 + 41, mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        pushExp("to_off",  e0 + 44, mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        waitUntil(e0 + 48);

        $display("[TB] late pgood");
        applyStimulus(1'b1, e0);
        pushUp(e0, 1'b0);
        waitUntil(e0 + 19);
        pgood = 1'b1;
        pushExp("pg_iso", e0 + 22, mk(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        pushExp("pg_ack", e0 + 23, mk(4'b1111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        waitUntil(e0 + 25);
        applyStimulus(1'b0, d0);
        pushDown(d0);
        waitUntil(d0 + 15);
`endif

        guard = 0;
        while (expQ.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected events, need 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
